// File: rtl/keypad_scan_rx.sv
// keypad_scan_rx: 4x4 matrix keypad scanner with per-press debounce and a key-code FIFO.
// Define KEYPAD_AUTOREPEAT_EN to build the held-key auto-repeat counter.
module keypad_scan_rx #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic                        sys_Clock,
  input  logic                        Reset,
  output logic [3:0]                  col_sel,
  input  logic [3:0]                  row_in,
  output logic [3:0]                  key_code,
  output logic                        key_valid,
  input  logic                        key_ack,
  output logic [$clog2(FIFO_DEPTH):0] key_count,
  output logic                        overflow,
  input  logic                        clr_ovf
);
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_SCANS);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [DW-1:0] DB_ZERO   = DW'(0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  if (SCAN_TICKS < 4 || FIFO_DEPTH < 2 || REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_scan_rx: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2, RELEASE = 2'd3} state_t;

  function automatic logic [2:0] ones4(input logic [3:0] v);
    ones4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] row_idx(input logic [3:0] v);
    case (v)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  endfunction

  logic          rst_meta_r, rst_n_r;
  logic [3:0]    row_meta_r, row_sync_r;
  logic [TW-1:0] tick_cnt_r;
  logic [1:0]    col_r;
  logic [3:0]    col_sel_r;
  logic [1:0]    acc_n_r;
  logic [3:0]    acc_code_r;
  logic          slot_end_s, scan_done_s, one_s, none_s;
  logic [3:0]    hits_s, scan_code_s;
  logic [2:0]    hit_n_s, sum_s;
  logic [1:0]    scan_n_s;

  // Reset synchronizer: assert immediately, release on the clock.
  always_ff @(posedge sys_Clock or negedge Reset) begin
    if (!Reset) begin
      rst_meta_r <= 1'b0;
      rst_n_r    <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_n_r    <= rst_meta_r;
    end
  end

  // Two-stage synchronizer for the asynchronous row sense lines.
  always_ff @(posedge sys_Clock or negedge rst_n_r) begin
    if (!rst_n_r) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row_in;
      row_sync_r <= row_meta_r;
    end
  end

  // Key count is saturated at 2 since only NONE/ONE/MULTI matter.
  always_comb begin
    slot_end_s  = (tick_cnt_r == TICK_LAST);
    scan_done_s = slot_end_s && (col_r == 2'd3);
    hits_s      = ~row_sync_r;
    hit_n_s     = ones4(hits_s);
    sum_s       = {1'b0, acc_n_r} + hit_n_s;
    if (sum_s >= 3'd2) scan_n_s = 2'd2;
    else scan_n_s = sum_s[1:0];
    if ((acc_n_r == 2'd0) && (hit_n_s == 3'd1)) scan_code_s = {row_idx(hits_s), col_r};
    else scan_code_s = acc_code_r;
    one_s  = (scan_n_s == 2'd1);
    none_s = (scan_n_s == 2'd0);
  end

  // Column timing and per-scan key accumulation.
  always_ff @(posedge sys_Clock or negedge rst_n_r) begin
    if (!rst_n_r) begin
      tick_cnt_r <= {TW{1'b0}};
      col_r      <= 2'd0;
      col_sel_r  <= 4'b1110;
      acc_n_r    <= 2'd0;
      acc_code_r <= 4'd0;
    end else if (slot_end_s) begin
      tick_cnt_r <= {TW{1'b0}};
      col_r      <= col_r + 2'd1;
      col_sel_r  <= ~(4'b0001 << (col_r + 2'd1));
      if (col_r == 2'd3) begin
        acc_n_r    <= 2'd0;
        acc_code_r <= 4'd0;
      end else begin
        acc_n_r    <= scan_n_s;
        acc_code_r <= scan_code_s;
      end
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
    end
  end

  state_t        state_r;
  logic [DW-1:0] cnt_r;
  logic [3:0]    cand_r, push_code_r;
  logic          push_r;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);
  logic [RW-1:0] rep_cnt_r;
`endif

  // Debounce FSM, advanced once per completed scan; push_r is a one-cycle strobe.
  always_ff @(posedge sys_Clock or negedge rst_n_r) begin
    if (!rst_n_r) begin
      state_r     <= IDLE;
      cnt_r       <= DB_ZERO;
      cand_r      <= 4'd0;
      push_r      <= 1'b0;
      push_code_r <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_r   <= {RW{1'b0}};
`endif
    end else begin
      push_r <= 1'b0;
      if (scan_done_s) begin
        case (state_r)
          IDLE: begin
            if (one_s) begin
              state_r <= DEBOUNCE;
              cand_r  <= scan_code_s;
              cnt_r   <= DB_ONE;
            end
          end
          DEBOUNCE: begin
            if (one_s && (scan_code_s == cand_r)) begin
              if ((cnt_r + DB_ONE) == DB_LAST) begin
                push_r      <= 1'b1;
                push_code_r <= cand_r;
                state_r     <= PRESSED;
                cnt_r       <= DB_ZERO;
              end else begin
                cnt_r <= cnt_r + DB_ONE;
              end
            end else if (one_s) begin
              cand_r <= scan_code_s;
              cnt_r  <= DB_ONE;
            end else begin
              state_r <= IDLE;
              cnt_r   <= DB_ZERO;
            end
          end
          PRESSED: begin
            if (none_s) begin
              state_r <= RELEASE;
              cnt_r   <= DB_ONE;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_r <= {RW{1'b0}};
            end else if (one_s && (scan_code_s == cand_r)) begin
              if ((rep_cnt_r + REP_ONE) == REP_LAST) begin
                push_r      <= 1'b1;
                push_code_r <= cand_r;
                rep_cnt_r   <= {RW{1'b0}};
              end else begin
                rep_cnt_r <= rep_cnt_r + REP_ONE;
              end
`endif
            end
          end
          RELEASE: begin
            if (none_s) begin
              if ((cnt_r + DB_ONE) == DB_LAST) begin
                state_r <= IDLE;
                cnt_r   <= DB_ZERO;
              end else begin
                cnt_r <= cnt_r + DB_ONE;
              end
            end else begin
              state_r <= PRESSED;
              cnt_r   <= DB_ZERO;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= DB_ZERO;
          end
        endcase
      end
    end
  end

  logic [3:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [CW-1:0] count_r, count_next_s;
  logic [3:0]    key_code_r, head_next_s;
  logic          key_valid_r, overflow_r, full_s, pop_s, push_acc_s;

  // A pop frees the slot the same cycle, so a push on full is kept when popping.
  always_comb begin
    full_s     = (count_r == CNT_FULL);
    pop_s      = key_ack && (count_r != CNT_ZERO);
    push_acc_s = push_r && (!full_s || pop_s);
    if (pop_s) rd_next_s = rd_ptr_r + PTR_ONE;
    else rd_next_s = rd_ptr_r;
    case ({push_acc_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    if (count_next_s == CNT_ZERO) head_next_s = key_code_r;
    else if (push_acc_s && (rd_next_s == wr_ptr_r)) head_next_s = push_code_r;
    else head_next_s = mem_r[rd_next_s];
  end

  // FIFO storage, pointers, registered head and sticky overflow.
  always_ff @(posedge sys_Clock or negedge rst_n_r) begin
    if (!rst_n_r) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 4'd0;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= CNT_ZERO;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (push_acc_s) begin
        mem_r[wr_ptr_r] <= push_code_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r    <= rd_next_s;
      count_r     <= count_next_s;
      key_code_r  <= head_next_s;
      key_valid_r <= (count_next_s != CNT_ZERO);
      if (push_r && full_s && !pop_s) overflow_r <= 1'b1;
      else if (clr_ovf) overflow_r <= 1'b0;
    end
  end

  assign col_sel   = col_sel_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_count = count_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_keypad_scan_rx.sv
// Self-checking bench for keypad_scan_rx: physical keypad model plus a scan-level reference model.
`timescale 1ns/1ps
module tb_keypad_scan_rx;
  localparam int SCAN_TICKS = 4;
  localparam int DB         = 2;
  localparam int DEPTH      = 4;
  localparam int REP        = 3;
  localparam int SCAN_CYC   = 4 * SCAN_TICKS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  col_sel, row_in, key_code;
  logic        key_valid, overflow;
  logic        key_ack = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [2:0]  key_count;
  logic [15:0] keys = 16'h0000;

  int errors = 0;
  int checks = 0;

  // Reference model state: FIFO contents, sticky flag, debounce run lengths.
  int q[$];
  bit ovf_m;
  int last_code_m;
  bit armed_m;
  int run_code_m, run_len_m, none_len_m, rep_m, pend_m;

  keypad_scan_rx #(
    .SCAN_TICKS(SCAN_TICKS), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(DEPTH), .REPEAT_SCANS(REP)
  ) dut (
    .sys_Clock(clk), .Reset(rst_n), .col_sel(col_sel), .row_in(row_in),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_count(key_count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row reads low when a pressed key sits on the driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_sel);
  end

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0; last_code_m = 0; armed_m = 1'b1;
    run_code_m = -1; run_len_m = 0; none_len_m = 0; rep_m = 0; pend_m = -1;
  endtask

  task automatic model_track_head();
    if (q.size() > 0) last_code_m = q[0];
  endtask

  // Accept after DB consecutive single-key scans of one code; re-arm after DB empty scans.
  task automatic model_scan(input logic [15:0] k);
    int n, code;
    n = $countones(k);
    code = -1;
    for (int i = 0; i < 16; i++) if (k[i]) code = i;
    pend_m = -1;
    if (armed_m) begin
      if (n == 1) begin
        run_len_m = (run_len_m > 0 && code == run_code_m) ? run_len_m + 1 : 1;
        run_code_m = code;
        if (run_len_m == DB) begin
          pend_m = code; armed_m = 1'b0; none_len_m = 0; rep_m = 0;
        end
      end else begin
        run_len_m = 0;
      end
    end else if (n == 0) begin
      none_len_m++;
      rep_m = 0;
      if (none_len_m == DB) begin armed_m = 1'b1; run_len_m = 0; end
    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
      if (none_len_m == 0 && n == 1 && code == run_code_m) begin
        rep_m++;
        if (rep_m == REP) begin pend_m = code; rep_m = 0; end
      end
`endif
      none_len_m = 0;
    end
  endtask

  // One full scan from just after the first edge of a scan to just after the next one.
  task automatic run_scan(input logic [15:0] k, input bit ack_first, input bit clr_first,
                          input bit ack_last, input bit clr_last);
    keys = k; key_ack = ack_first; clr_ovf = clr_first;
    @(posedge clk); #1;
    if (ack_first && q.size() > 0) void'(q.pop_front());
    if (clr_first) ovf_m = 1'b0;
    model_track_head();
    key_ack = 1'b0; clr_ovf = 1'b0;
    repeat (SCAN_CYC - 2) @(posedge clk);
    #1;
    model_scan(k);
    key_ack = ack_last; clr_ovf = clr_last;
    @(posedge clk); #1;
    key_ack = 1'b0; clr_ovf = 1'b0;
    if (clr_last) ovf_m = 1'b0;
    if (ack_last && q.size() > 0) void'(q.pop_front());
    if (pend_m >= 0) begin
      if (q.size() == DEPTH) ovf_m = 1'b1;
      else q.push_back(pend_m);
    end
    model_track_head();
  endtask

  task automatic align();
    int budget;
    bit seen;
    budget = 0; seen = 1'b0;
    while (budget < 200 && !(seen && col_sel == 4'b1110)) begin
      @(posedge clk); #1;
      if (col_sel == 4'b0111) seen = 1'b1;
      budget++;
    end
    checks++;
    if (budget >= 200) begin
      errors++;
      $display("FAIL align: col_sel=%b never returned to 1110 after 0111", col_sel);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (col_sel !== 4'b1110) begin errors++; $display("FAIL reset_col: col_sel=%b expected 1110", col_sel); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: key_valid=%b expected 0", key_valid); end
    checks++; if (key_count !== 3'd0) begin errors++; $display("FAIL reset_count: key_count=%0d expected 0", key_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: overflow=%b expected 0", overflow); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: key_code=%h expected 0", key_code); end
    rst_n = 1'b1;
    model_reset();
    align();
  endtask

  task automatic test_scan_order();
    logic [3:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp = ~(4'b0001 << (i % 4));
      checks++;
      if (col_sel !== exp) begin errors++; $display("FAIL scan_order[%0d]: col_sel=%b expected %b", i, col_sel, exp); end
      repeat (SCAN_TICKS) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_key();
    logic [15:0] k;
    k = 16'h0001 << 9;
    run_scan(k, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_early: key_valid=%b expected 0", key_valid); end
    run_scan(k, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL single_valid: key_valid=%b expected 1", key_valid); end
    checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL single_code: key_code=%h expected 9", key_code); end
    checks++; if (key_count !== 3'(q.size())) begin errors++; $display("FAIL single_count: key_count=%0d expected %0d", key_count, q.size()); end
    run_scan(k, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_ack: key_valid=%b expected 0", key_valid); end
    checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL single_hold_code: key_code=%h expected 9", key_code); end
    for (int i = 0; i < 10; i++) begin
      run_scan(k, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (key_count !== 3'(q.size())) begin errors++; $display("FAIL single_held[%0d]: key_count=%0d expected %0d", i, key_count, q.size()); end
    end
    repeat (2) run_scan(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 8; i++) begin
      run_scan((i % 2 == 0) ? (16'h0001 << 3) : 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (key_count !== 3'd0 || q.size() != 0) begin errors++; $display("FAIL bounce[%0d]: key_count=%0d expected 0 (model %0d)", i, key_count, q.size()); end
    end
  endtask

  task automatic test_multi();
    for (int i = 0; i < 8; i++) begin
      run_scan(16'h0050, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (key_count !== 3'd0) begin errors++; $display("FAIL multi[%0d]: key_count=%0d expected 0", i, key_count); end
    end
    repeat (2) run_scan(16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (key_count !== 3'd1) begin errors++; $display("FAIL multi_release_count: key_count=%0d expected 1", key_count); end
    checks++; if (key_code !== 4'h4) begin errors++; $display("FAIL multi_release_code: key_code=%h expected 4", key_code); end
    run_scan(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_scan(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_release(input int code, input bit ack_last, input bit clr_last);
    run_scan(16'h0001 << code, 1'b0, 1'b0, 1'b0, 1'b0);
    run_scan(16'h0001 << code, 1'b0, 1'b0, ack_last, clr_last);
  endtask

  task automatic test_overflow();
    for (int c = 1; c <= 5; c++) begin
      press_release(c, 1'b0, 1'b0);
      repeat (2) run_scan(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++; if (key_count !== 3'd4) begin errors++; $display("FAIL ovf_count: key_count=%0d expected 4", key_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: overflow=%b expected 1", overflow); end
    checks++; if (key_code !== 4'h1) begin errors++; $display("FAIL ovf_head: key_code=%h expected 1", key_code); end
    press_release(6, 1'b1, 1'b0);
    checks++; if (key_count !== 3'd4) begin errors++; $display("FAIL pushpop_count: key_count=%0d expected 4", key_count); end
    checks++; if (key_code !== 4'h2) begin errors++; $display("FAIL pushpop_head: key_code=%h expected 2", key_code); end
    repeat (2) run_scan(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    press_release(7, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: overflow=%b expected 1", overflow); end
    run_scan(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: overflow=%b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      run_scan(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (key_count !== 3'(q.size()) || key_code !== 4'(last_code_m)) begin
        errors++;
        $display("FAIL drain[%0d]: count=%0d code=%h expected count=%0d code=%h", i, key_count, key_code, q.size(), 4'(last_code_m));
      end
    end
    checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL empty_hold: key_code=%h expected 6", key_code); end
  endtask

  task automatic test_random();
    logic [15:0] k;
    int hold, sel;
    k = 16'h0000; hold = 0;
    for (int i = 0; i < 40; i++) begin
      if (hold == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 4) k = 16'h0000;
        else if (sel < 9) k = 16'h0001 << (4 * $urandom_range(0, 3) + $urandom_range(0, 1));
        else k = 16'h8001;
        hold = $urandom_range(1, 3);
      end
      hold--;
      run_scan(k, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 5) == 0), 1'b0);
      checks++;
      if (key_count !== 3'(q.size()) || key_valid !== (q.size() > 0) ||
          key_code !== 4'(last_code_m) || overflow !== ovf_m) begin
        errors++;
        $display("FAIL random[%0d]: cnt=%0d val=%b code=%h ovf=%b expected cnt=%0d val=%b code=%h ovf=%b",
                 i, key_count, key_valid, key_code, overflow, q.size(), (q.size() > 0), 4'(last_code_m), ovf_m);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_scan(16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    keys = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (key_count !== 3'd0 || key_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_fifo: count=%0d valid=%b expected 0 0", key_count, key_valid); end
    checks++; if (col_sel !== 4'b1110) begin errors++; $display("FAIL mid_reset_col: col_sel=%b expected 1110", col_sel); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_ovf: overflow=%b expected 0", overflow); end
    rst_n = 1'b1;
    model_reset();
    align();
    run_scan(16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    run_scan(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (key_count !== 3'd0) begin errors++; $display("FAIL fresh_debounce: key_count=%0d expected 0", key_count); end
    repeat (2) run_scan(16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (key_count !== 3'd1 || key_code !== 4'h5) begin errors++; $display("FAIL after_reset_press: count=%0d code=%h expected 1 5", key_count, key_code); end
    run_scan(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_scan(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    for (int i = 0; i < 2 + 9; i++) run_scan(16'h0080, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (key_count !== 3'd4 || q.size() != 4) begin errors++; $display("FAIL repeat_count: key_count=%0d expected 4 (model %0d)", key_count, q.size()); end
    checks++; if (key_code !== 4'h7 || overflow !== 1'b0) begin errors++; $display("FAIL repeat_code: code=%h ovf=%b expected 7 0", key_code, overflow); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_scan_order();
    test_single_key();
    test_bounce();
    test_multi();
    test_overflow();
    test_random();
    test_reset_mid();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
